// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoder definitions: opcodes, request kind codes and FSM states.
package rv_enc_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] KIND_R      = 3'd0;
    localparam logic [2:0] KIND_I      = 3'd1;
    localparam logic [2:0] KIND_LOAD   = 3'd2;
    localparam logic [2:0] KIND_STORE  = 3'd3;
    localparam logic [2:0] KIND_BRANCH = 3'd4;
    localparam logic [2:0] KIND_LUI    = 3'd5;
    localparam logic [2:0] KIND_JAL    = 3'd6;
    localparam logic [2:0] KIND_LI     = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        LI_LO = 1'b1
    } state_t;

endpackage

// File: rtl/inst_field_pack.sv
// Combinational RV32I field packer: one request kind plus fields -> instruction word.
module inst_field_pack
    import rv_enc_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  f3,
    input  logic        alt,
    input  logic [31:0] imm,
    output logic [31:0] instr
);

    always_comb begin
        instr = '0;
        case (kind)
            KIND_R:      instr = {1'b0, alt, 5'b00000, rs2, rs1, f3, rd, OP_R};
            KIND_I: begin
                instr = {imm[11:0], rs1, f3, rd, OP_I};
                // Shift-immediate forms carry alt in bit 30 and a 5-bit shamt.
                if (f3 == 3'b001 || f3 == 3'b101)
                    instr[31:20] = {1'b0, alt, 5'b00000, imm[4:0]};
            end
            KIND_LOAD:   instr = {imm[11:0], rs1, f3, rd, OP_LOAD};
            KIND_STORE:  instr = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            KIND_BRANCH: instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            KIND_LUI:    instr = {imm[31:12], rd, OP_LUI};
            KIND_JAL:    instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            default:     instr = '0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder with LI pseudo-instruction expansion.
module inst_encoder
    import rv_enc_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [2:0]  req_funct3,
    input  logic        req_alt,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        busy
);

    state_t      state;
    logic [4:0]  liRd;
    logic [11:0] liLo;

    logic        slotFree;
    logic        accept;
    logic        liSmall;
    logic [19:0] liHi;

    logic [2:0]  pKind;
    logic [4:0]  pRd, pRs1, pRs2;
    logic [2:0]  pF3;
    logic        pAlt;
    logic [31:0] pImm;
    logic        pLast;
    logic [31:0] packed_instr;

    assign slotFree  = !out_valid || out_ready;
    assign req_ready = (state == IDLE) && slotFree;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE) || out_valid;

    assign liSmall = (&req_imm[31:11]) || !(|req_imm[31:11]);
    assign liHi    = req_imm[31:12] + {19'b0, req_imm[11]};

    // A single packer serves both the request word and the deferred LI ADDI.
    always_comb begin
        pKind = req_kind;
        pRd   = req_rd;
        pRs1  = req_rs1;
        pRs2  = req_rs2;
        pF3   = req_funct3;
        pAlt  = req_alt;
        pImm  = req_imm;
        pLast = 1'b1;
        if (state == LI_LO) begin
            pKind = KIND_I;
            pRd   = liRd;
            pRs1  = liRd;
            pRs2  = '0;
            pF3   = 3'b000;
            pAlt  = 1'b0;
            pImm  = {20'b0, liLo};
        end else if (req_kind == KIND_LI) begin
            pRs2 = '0;
            pF3  = 3'b000;
            pAlt = 1'b0;
            if (liSmall) begin
                pKind = KIND_I;
                pRs1  = '0;
                pImm  = {20'b0, req_imm[11:0]};
            end else begin
                pKind = KIND_LUI;
                pImm  = {liHi, 12'b0};
                pLast = (req_imm[11:0] == 12'h000);
            end
        end
    end

    inst_field_pack u_pack (
        .kind  (pKind),
        .rd    (pRd),
        .rs1   (pRs1),
        .rs2   (pRs2),
        .f3    (pF3),
        .alt   (pAlt),
        .imm   (pImm),
        .instr (packed_instr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_instr <= RESET_INSTR;
            liRd      <= '0;
            liLo      <= '0;
        end else if (state == LI_LO) begin
            if (slotFree) begin
                out_valid <= 1'b1;
                out_instr <= packed_instr;
                out_last  <= 1'b1;
                state     <= IDLE;
            end
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= packed_instr;
            out_last  <= pLast;
            if (!pLast) begin
                state <= LI_LO;
                liRd  <= req_rd;
                liLo  <= req_imm[11:0];
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of the main decoder. It takes field-level encode requests (kind, registers, funct3, immediate) and produces 32-bit instruction words on a valid/ready stream. That stream feeds the instruction-memory preload / boot-injection path of the pipeline. It also expands the LI pseudo-instruction into one or two real instructions.

Parameters:
RESET_INSTR, 32'h0000_0000, value held on out_instr during and after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  an encode request is presented
req_ready  output  1  the encoder accepts the request this cycle
req_kind  input  3  0 R_ALU, 1 I_ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 JAL, 7 LI (pseudo)
req_rd  input  5  destination register
req_rs1  input  5  source register 1
req_rs2  input  5  source register 2
req_funct3  input  3  funct3 field (ignored for LUI, JAL, LI)
req_alt  input  1  sets instr[30] for R_ALU, and for I_ALU shifts (funct3 001/101)
req_imm  input  32  immediate, full 32-bit value, with per-kind field selection
out_valid  output  1  out_instr is valid
out_ready  input  1  the consumer takes the word this cycle
out_instr  output  32  encoded instruction
out_last  output  1  this word is the final word of its request
busy  output  1  the state machine is not IDLE, or out_valid is high

Behaviour:
- Reset (synchronous, sampled at a clk edge):
  - out_valid=0, out_last=0, out_instr=RESET_INSTR, state=IDLE.
  - A pending LI second word is discarded.
- Transfer rule: a transfer occurs on any edge where valid&&ready. The slot is free when !out_valid || out_ready.
- req_ready = (state==IDLE) && slot free. It is combinational and never depends on req_valid.
- Accepting a request loads out_instr on the same edge, so latency is 1 cycle.
- Sustained throughput is one word per cycle when out_ready is held at 1.
- Hold rule: while out_valid && !out_ready, out_instr and out_last hold stable. If no new word loads on a transfer edge, out_valid drops to 0.
- Opcodes by kind:
  - R_ALU 0110011, I_ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, JAL 1101111.
  - LI uses LUI and/or I_ALU ADDI (funct3 000).
- Field packing:
  - R: instr = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, op}.
  - I: instr = {imm[11:0], rs1, f3, rd, op}. For I_ALU with f3 = 001 or 101, instr[31:25] = {0, alt, 00000} and instr[24:20] = imm[4:0].
  - S: instr = {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}. imm[0] is ignored.
  - U: instr = {imm[31:12], rd, op}.
  - J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}. imm[0] is ignored.
- All non-LI kinds emit exactly one word with out_last=1.
- LI expansion. Define lo=imm[11:0] and hi=imm[31:12]+imm[11], with 20-bit wrap-around (0xFFFFF+1 -> 0x00000).
  - If imm[31:11] is all 0s or all 1s: emit a single ADDI rd,x0,lo with out_last=1.
  - Else if lo==0: emit a single LUI rd,hi with out_last=1.
  - Else: emit LUI rd,hi with out_last=0, then go to state LI_LO.
  - Latch rd and lo internally; request inputs may change after acceptance.
- FSM states:
  - IDLE: accepts requests.
  - LI_LO: req_ready=0. When the slot is free, load ADDI rd,rd,lo with out_last=1 and go to IDLE on that same edge.
- Boundary cases:
  - LI with rd=x0 is encoded normally, with no special case.
  - In IDLE, the ADDI of a prior LI and a new request never compete for the slot.
  - Reset asserted in LI_LO returns to IDLE with out_valid=0.
- busy = (state!=IDLE) || out_valid.

Decomposition:
- Shared package (rv_enc_pkg):
  - 7-bit opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_LUI; reuse the same values as the decoder).
  - 3-bit KIND_* codes.
  - FSM state enum {IDLE, LI_LO}.
- One combinational sub-module, inst_field_pack: (kind, rd, rs1, rs2, f3, alt, imm) -> instr[31:0].
  - It is used for both the first and the second LI word.
  - The parent owns the FSM, the LI split and the output register.

Test Plan:
- R_ALU: rd=3, rs1=1, rs2=2, f3=0, alt=0 -> 0x002081B3, out_last=1. Same with alt=1 -> 0x402081B3.
- STORE rs1=1, rs2=2, f3=010, imm=8 -> 0x0020A423. BRANCH rs1=1, rs2=2, f3=000, imm=-4 -> 0xFE208EE3.
- LI rd=5, imm=0x12345FFF -> 0x123462B7 (last=0), then 0xFFF28293 (last=1). req_ready=0 in the cycle between the two words.
- LI rd=1, imm=0x000007FF -> single 0x7FF00093. LI rd=1, imm=0x00010000 -> single LUI 0x000100B7, out_last=1.
- Back-pressure: hold out_ready=0 for 5 cycles after the first LI word -> out_instr stays 0x123462B7 and req_ready stays 0. Releasing out_ready delivers both words in order.
- Assert reset while in LI_LO with out_valid=1 -> next cycle out_valid=0, busy=0, req_ready=1. No ADDI is ever emitted.
